// File: rtl/mata_poly_reader.sv
// mata_poly_reader: streams polynomial A[k][l] out of the matA RAM (port B)
// as a valid/ready coefficient stream, one coefficient per cycle when the
// consumer keeps out_ready high. A 2-entry buffer covers the 1-cycle RAM
// read latency.
//
// Build option: define MATA_RANGE_CHECK_EN to add the sticky range_err
// output, which flags any streamed coefficient >= Q.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; illegal indices raise err
// S_READ  | issuing reads base+0 .. base+N-1, gated by buffer space
// S_DRAIN | all reads issued; waiting for the out_last handshake

module mata_poly_reader #(
    parameter int K           = 8,
    parameter int L           = 7,
    parameter int N           = 256,
    parameter int COEFF_WIDTH = 24,
    parameter int ADDR_WIDTH  = $clog2(K*L*N)
`ifdef MATA_RANGE_CHECK_EN
    ,
    parameter int unsigned Q  = 8380417
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             k_idx,
    input  logic [3:0]             l_idx,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    input  logic [COEFF_WIDTH-1:0] ram_dout,
    output logic [COEFF_WIDTH-1:0] coeff_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last
`ifdef MATA_RANGE_CHECK_EN
    ,
    output logic                   range_err
`endif
);

    localparam int                    CNT_W      = $clog2(N) + 1;
    localparam logic [CNT_W-1:0]      N_CNT      = CNT_W'(N);
    localparam logic [CNT_W-1:0]      N_LAST     = CNT_W'(N - 1);
    localparam logic [3:0]            K_LIM      = 4'(K);
    localparam logic [3:0]            L_LIM      = 4'(L);
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(L * N);
    localparam logic [ADDR_WIDTH-1:0] COL_STRIDE = ADDR_WIDTH'(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             k_q, l_q;
    logic [CNT_W-1:0]       n_issue_q, n_out_q;
    logic                   inflight_q;
    logic [1:0]             occ_q;
    logic [COEFF_WIDTH-1:0] buf0_q, buf1_q;
    logic                   done_q, err_q;

    logic                   accept, done_d, err_d;
    logic                   issue, pop, last_hs;
    logic [1:0]             fill;
    logic [ADDR_WIDTH-1:0]  base;

    // Stream side of the buffer: head entry drives the output
    assign out_valid = (occ_q != 2'd0);
    assign coeff_out = buf0_q;
    assign out_last  = out_valid && (n_out_q == N_LAST);
    assign pop       = out_valid && out_ready;
    assign last_hs   = pop && out_last;

    // Address generation from the latched indices
    assign base     = ADDR_WIDTH'(k_q) * ROW_STRIDE + ADDR_WIDTH'(l_q) * COL_STRIDE;
    assign ram_addr = base + ADDR_WIDTH'(n_issue_q);

    // Space check counts the entry leaving this cycle so a full-rate stream
    // never stalls on its own read pipeline.
    assign fill  = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    assign issue = (state_q == S_READ) && (n_issue_q < N_CNT) && (fill < 2'd2);

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign err  = err_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and start/done/err decisions
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((k_idx < K_LIM) && (l_idx < L_LIM)) begin
                        accept  = 1'b1;
                        state_d = S_READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (issue && (n_issue_q == N_LAST)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (last_hs) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counters, read pipeline flag, output buffer and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q        <= '0;
            l_q        <= '0;
            n_issue_q  <= '0;
            n_out_q    <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q     <= done_d;
            err_q      <= err_d;
            inflight_q <= issue;
            if (accept) begin
                k_q       <= k_idx;
                l_q       <= l_idx;
                n_issue_q <= '0;
                n_out_q   <= '0;
            end else begin
                if (issue) n_issue_q <= n_issue_q + 1'b1;
                if (pop)   n_out_q   <= n_out_q + 1'b1;
            end
            case ({inflight_q, pop})
                2'b10: begin
                    if (occ_q == 2'd0) buf0_q <= ram_dout;
                    else               buf1_q <= ram_dout;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    buf0_q <= buf1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        buf0_q <= ram_dout;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= ram_dout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MATA_RANGE_CHECK_EN
    // Sticky flag for out-of-range coefficients actually transferred
    always_ff @(posedge clk) begin
        if (rst || accept)                                   range_err <= 1'b0;
        else if (pop && (coeff_out >= COEFF_WIDTH'(Q)))      range_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_mata_poly_reader.sv
// Testbench for mata_poly_reader: table of start requests plus hand-written
// reset-abort and range-check sequences against a behavioural RAM model.
module tb_mata_poly_reader;

    localparam int K = 8, L = 7, N = 256, CW = 24, AW = 14;
    localparam int MEM_D = 1 << AW;
    localparam int Q_VAL = 8380417;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [3:0]    k_idx, l_idx;
    logic          busy, done, err;
    logic [AW-1:0] ram_addr;
    logic [CW-1:0] ram_dout, coeff_out;
    logic          out_valid, out_ready, out_last;
`ifdef MATA_RANGE_CHECK_EN
    logic          range_err;
`endif

    logic [CW-1:0] mem [0:MEM_D-1];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Synchronous read port B model
    always @(posedge clk) ram_dout <= mem[ram_addr];

    mata_poly_reader #(.K(K), .L(L), .N(N), .COEFF_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_idx(k_idx), .l_idx(l_idx),
        .busy(busy), .done(done), .err(err), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .coeff_out(coeff_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
`ifdef MATA_RANGE_CHECK_EN
        , .range_err(range_err)
`endif
    );

    typedef struct {
        logic [3:0] k;
        logic [3:0] l;
        int         mode;      // 0: ready high, 1: fixed stall pattern, 2: random
        bit         poke;      // inject a start while busy
        bit         exp_err;
        int         exp_base;
    } vec_t;

    vec_t vecs [7];

    task automatic check_eq(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int mode, input int cyc);
        logic [15:0] pat;
        pat = 16'b1001_1001_0110_1001;
        case (mode)
            0:       return 1'b1;
            1:       return pat[4'(cyc)];
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_stream(input vec_t v, input string name);
        int cnt, cyc, first_valid, hs_last_cyc;
        bit got_done, stalled, busy_ok, big;
        logic [CW-1:0] held_d, exp_d;
        logic held_l;
        cnt = 0; first_valid = -1; hs_last_cyc = -10;
        got_done = 0; stalled = 0; busy_ok = 1; big = 0;
        held_d = '0; held_l = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; k_idx = v.k; l_idx = v.l; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!got_done && cyc < 3000) begin
            out_ready = rdy(v.mode, cyc);
            if (v.poke) begin
                start = (cyc == 40);
                k_idx = 4'd0; l_idx = 4'd0;
            end
            @(negedge clk);
            if (cyc == 1) begin
                check_eq({name, "_busy_after_start"}, busy, 1);
`ifdef MATA_RANGE_CHECK_EN
                check_eq({name, "_range_cleared"}, range_err, 0);
`endif
            end
            if (stalled) begin
                check_eq({name, "_hold_valid"}, out_valid, 1);
                check_eq({name, "_hold_data"}, coeff_out, held_d);
                check_eq({name, "_hold_last"}, out_last, held_l);
            end
            stalled = 0;
            if (done) begin
                got_done = 1;
                check_eq({name, "_count"}, cnt, N);
                check_eq({name, "_done_timing"}, cyc, hs_last_cyc + 1);
                check_eq({name, "_busy_at_done"}, busy, 0);
                check_eq({name, "_valid_at_done"}, out_valid, 0);
            end else if (!busy) begin
                busy_ok = 0;
            end
            if (out_valid && !done) begin
                if (first_valid < 0) first_valid = cyc;
                if (out_ready) begin
                    if (cnt >= N) begin
                        check_eq({name, "_extra_transfer"}, cnt, N - 1);
                    end else begin
                        exp_d = mem[v.exp_base + cnt];
                        check_eq({name, "_coeff"}, coeff_out, exp_d);
                        check_eq({name, "_last"}, out_last, (cnt == N - 1));
`ifdef MATA_RANGE_CHECK_EN
                        check_eq({name, "_range_err"}, range_err, big);
`endif
                        if (exp_d >= CW'(Q_VAL)) big = 1;
                        if (cnt == N - 1) hs_last_cyc = cyc;
                    end
                    cnt++;
                end else begin
                    stalled = 1;
                    held_d  = coeff_out;
                    held_l  = out_last;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        check_eq({name, "_done_seen"}, got_done, 1);
        check_eq({name, "_busy_throughout"}, busy_ok, 1);
        if (v.mode == 0) check_eq({name, "_first_valid_cycle"}, first_valid, 3);
`ifdef MATA_RANGE_CHECK_EN
        check_eq({name, "_range_final"}, range_err, big);
`endif
    endtask

    task automatic run_err(input vec_t v, input string name);
        bit quiet;
        quiet = 1;
        @(posedge clk); #1;
        start = 1'b1; k_idx = v.k; l_idx = v.l; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_eq({name, "_err_pulse"}, err, 1);
        check_eq({name, "_busy"}, busy, 0);
        check_eq({name, "_valid"}, out_valid, 0);
        @(negedge clk);
        check_eq({name, "_err_one_cycle"}, err, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy || out_valid || done) quiet = 0;
        end
        check_eq({name, "_stays_idle"}, quiet, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        int  cnt, cyc;
        bit  quiet;
        vec_t v;
        rst = 1'b1; start = 1'b0; k_idx = '0; l_idx = '0; out_ready = 1'b0;
        for (int i = 0; i < MEM_D; i++) mem[i] = CW'(i);

        vecs[0] = '{4'd0,  4'd0,  0, 1'b0, 1'b0, 0};
        vecs[1] = '{4'd7,  4'd6,  0, 1'b0, 1'b0, 14080};
        vecs[2] = '{4'd2,  4'd3,  1, 1'b0, 1'b0, 4352};
        vecs[3] = '{4'd8,  4'd0,  0, 1'b0, 1'b1, 0};
        vecs[4] = '{4'd3,  4'd7,  0, 1'b0, 1'b1, 0};
        vecs[5] = '{4'd5,  4'd1,  2, 1'b1, 1'b0, 9216};
        vecs[6] = '{4'd15, 4'd15, 0, 1'b0, 1'b1, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_err", err, 0);
        check_eq("reset_valid", out_valid, 0);
        check_eq("reset_last", out_last, 0);
        check_eq("reset_coeff", coeff_out, 0);
        check_eq("reset_addr", ram_addr, 0);
`ifdef MATA_RANGE_CHECK_EN
        check_eq("reset_range_err", range_err, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].exp_err) run_err(vecs[i], $sformatf("vec%0d", i));
            else                 run_stream(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset after 100 transfers aborts the stream without a done pulse
        @(posedge clk); #1;
        start = 1'b1; k_idx = 4'd0; l_idx = 4'd3; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0; cyc = 0;
        while (cnt < 100 && cyc < 1000) begin
            @(negedge clk);
            if (out_valid && out_ready) cnt++;
            cyc++;
        end
        check_eq("abort_pre_transfers", cnt, 100);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_valid", out_valid, 0);
        check_eq("abort_busy", busy, 0);
        quiet = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || out_valid || busy) quiet = 0;
        end
        check_eq("abort_no_done", quiet, 1);
        out_ready = 1'b0;
        v = '{4'd1, 4'd1, 0, 1'b0, 1'b0, 2048};
        run_stream(v, "after_abort");

`ifdef MATA_RANGE_CHECK_EN
        mem[5] = CW'(Q_VAL);
        v = '{4'd0, 4'd0, 0, 1'b0, 1'b0, 0};
        run_stream(v, "range_hit");
        @(negedge clk);
        check_eq("range_sticky_idle", range_err, 1);
        mem[5] = CW'(5);
        v = '{4'd0, 4'd1, 1, 1'b0, 1'b0, 256};
        run_stream(v, "range_clear");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
